// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_pkg
//  Purpose  : Shared master-count, owner encodings and active-low levels
//  Revision : 1.0
// ============================================================================
package bus_arbiter_pkg;

    localparam int BUS_MASTER_CH    = 4;
    localparam int BUS_MASTER_IDX_W = 2;

    typedef logic [BUS_MASTER_IDX_W-1:0] bus_owner_t;

    localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [BUS_MASTER_CH-1:0] GRANT_RESET_ = 4'b1110;

    // Active-low one-cold grant vector for a given owner index.
    function automatic logic [BUS_MASTER_CH-1:0] owner_grant_(input bus_owner_t owner);
        logic [BUS_MASTER_CH-1:0] v;
        v        = {BUS_MASTER_CH{DISABLE_}};
        v[owner] = ENABLE_;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_rr_pick4
//  Purpose  : Round-robin search of the three masters after the current owner
//  Revision : 1.0
// ============================================================================
module bus_arbiter_rr_pick4
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] i_owner,
    input  logic [3:0] i_req_,
    output logic [1:0] o_next,
    output logic       o_found
);

    logic [1:0] w_cand [3];
    logic [2:0] w_hit;

    // Candidate k sits k places after the owner; 2-bit add gives the mod-4 wrap.
    for (genvar k = 0; k < 3; k++) begin : g_cand
        assign w_cand[k] = i_owner + 2'(k + 1);
        assign w_hit[k]  = (i_req_[w_cand[k]] == ENABLE_);
    end

    always_comb begin
        o_next  = i_owner;
        o_found = 1'b0;
        if (w_hit[0]) begin
            o_next  = w_cand[0];
            o_found = 1'b1;
        end else if (w_hit[1]) begin
            o_next  = w_cand[1];
            o_found = 1'b1;
        end else if (w_hit[2]) begin
            o_next  = w_cand[2];
            o_found = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Four-master round-robin bus arbiter with parking and hold limit
//  Revision : 1.0
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] m_req_,
    input  logic [3:0] m_as_,
    output logic [3:0] m_grnt_,
    output logic [1:0] bus_owner,
    output logic       owner_chg
);

    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(HOLD_MAX);

    bus_owner_t       r_owner;
    logic [3:0]       r_grnt_;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_owner_chg;

    logic       w_own_req;
    logic       w_own_idle;
    logic       w_others_req;
    logic       w_at_limit;
    logic       w_cnt_sat;
    logic       w_force;
    logic       w_rel;
    logic       w_change;
    logic [1:0] w_next;
    logic       w_found;

    bus_arbiter_rr_pick4 u_pick (
        .i_owner (r_owner),
        .i_req_  (m_req_),
        .o_next  (w_next),
        .o_found (w_found)
    );

    assign w_own_req  = (m_req_[r_owner] == ENABLE_);
    assign w_own_idle = (m_as_[r_owner]  == DISABLE_);
    // r_grnt_ is high for every non-owner, so it masks the owner out of the request set.
    assign w_others_req = |((~m_req_) & r_grnt_);

    if (HOLD_MAX != 0) begin : g_limit_on
        assign w_at_limit = (r_hold_cnt >= c_hold_max);
        assign w_cnt_sat  = (r_hold_cnt == c_hold_max);
    end else begin : g_limit_off
        assign w_at_limit = 1'b0;
        assign w_cnt_sat  = 1'b1;
    end

    assign w_force  = w_at_limit & w_own_idle & w_others_req;
    assign w_rel    = ~w_own_req | w_force;
    assign w_change = w_rel & w_found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= BUS_OWNER_MASTER_0;
            r_grnt_     <= GRANT_RESET_;
            r_hold_cnt  <= '0;
            r_owner_chg <= 1'b0;
        end else if (w_change) begin
            r_owner     <= w_next;
            r_grnt_     <= owner_grant_(w_next);
            r_hold_cnt  <= '0;
            r_owner_chg <= 1'b1;
        end else begin
            r_owner_chg <= 1'b0;
            if (!w_own_req) begin
                r_hold_cnt <= '0;
            end else if (!w_cnt_sat) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign m_grnt_   = r_grnt_;
    assign bus_owner = r_owner;
    assign owner_chg = r_owner_chg;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Self-checking bench for bus_arbiter against a behavioural model
//  Revision : 1.0
// ============================================================================
module tb_bus_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_a, as_a, grnt_a;
    logic [1:0] owner_a;
    logic       chg_a;
    logic [3:0] req_b, as_b, grnt_b;
    logic [1:0] owner_b;
    logic       chg_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_owner = 0;
    int   m_cnt   = 0;
    logic m_chg   = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(.HOLD_MAX(HM), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (req_a),
        .m_as_     (as_a),
        .m_grnt_   (grnt_a),
        .bus_owner (owner_a),
        .owner_chg (chg_a)
    );

    bus_arbiter #(.HOLD_MAX(0), .CNT_W(5)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (req_b),
        .m_as_     (as_b),
        .m_grnt_   (grnt_b),
        .bus_owner (owner_b),
        .owner_chg (chg_b)
    );

    function automatic logic [3:0] exp_grnt(input int o);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << o);
    endfunction

    // One arbitration decision, written straight from the ownership rules.
    task automatic model_step();
        bit own_req, others, frc;
        int pick;
        own_req = !req_a[m_owner];
        others  = 0;
        for (int j = 0; j < 4; j++)
            if (j != m_owner && !req_a[j]) others = 1;
        frc  = (HM != 0) && (m_cnt >= HM) && as_a[m_owner] && others;
        pick = -1;
        if (!own_req || frc)
            for (int k = 1; k <= 3; k++)
                if (pick < 0 && !req_a[(m_owner + k) % 4]) pick = (m_owner + k) % 4;
        if (pick >= 0) begin
            m_owner = pick;
            m_cnt   = 0;
            m_chg   = 1'b1;
        end else begin
            m_chg = 1'b0;
            m_cnt = own_req ? ((m_cnt < HM) ? m_cnt + 1 : HM) : 0;
        end
    endtask

    task automatic step_a();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_chg   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_a = 4'b0000; as_a = 4'b1111;
        req_b = 4'b0000; as_b = 4'b1111;
        #12;
        n_tests++;
        if ({grnt_a, owner_a, chg_a} !== {4'b1110, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got grnt=%b owner=%0d chg=%b want 1110/0/0", grnt_a, owner_a, chg_a);
        end
        n_tests++;
        if ({grnt_b, owner_b, chg_b} !== {4'b1110, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got grnt=%b owner=%0d chg=%b want 1110/0/0", grnt_b, owner_b, chg_b);
        end
        @(negedge clk);
        req_a = 4'b1111; req_b = 4'b1111;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step_a();
            n_tests++;
            if ({grnt_a, owner_a, chg_a} !== {4'b1110, 2'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL park_after_reset: cyc %0d got grnt=%b owner=%0d chg=%b want 1110/0/0", i, grnt_a, owner_a, chg_a);
            end
        end
    endtask

    task automatic test_round_robin();
        req_a = 4'b1001;                 // masters 1 and 2 request
        step_a();
        n_tests++;
        if (owner_a !== 2'd1 || chg_a !== 1'b1 || grnt_a !== 4'b1101) begin
            n_fail++;
            $display("FAIL rr_first: got owner=%0d chg=%b grnt=%b want 1/1/1101", owner_a, chg_a, grnt_a);
        end
        step_a();
        n_tests++;
        if (owner_a !== 2'd1 || chg_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_hold: got owner=%0d chg=%b want 1/0", owner_a, chg_a);
        end
        req_a = 4'b1011;                 // master 1 drops
        step_a();
        n_tests++;
        if (owner_a !== 2'd2 || chg_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_second: got owner=%0d chg=%b want 2/1", owner_a, chg_a);
        end
        req_a = 4'b1111;                 // master 2 drops, park
        for (int i = 0; i < 5; i++) begin
            step_a();
            n_tests++;
            if (owner_a !== 2'd2 || chg_a !== 1'b0 || grnt_a !== 4'b1011) begin
                n_fail++;
                $display("FAIL rr_park: cyc %0d got owner=%0d chg=%b grnt=%b want 2/0/1011", i, owner_a, chg_a, grnt_a);
            end
        end
    endtask

    task automatic test_wrap();
        req_a = 4'b0111;
        step_a();
        n_tests++;
        if (owner_a !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_setup: got owner=%0d want 3", owner_a);
        end
        req_a = 4'b1100;                 // owner 3 released, masters 0 and 1 request
        step_a();
        n_tests++;
        if (owner_a !== 2'd0 || grnt_a !== 4'b1110 || chg_a !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: got owner=%0d grnt=%b chg=%b want 0/1110/1", owner_a, grnt_a, chg_a);
        end
    endtask

    task automatic test_hold_limit();
        req_a = 4'b1101; as_a = 4'b1111;
        step_a();
        req_a = 4'b1001;                 // master 1 keeps, master 2 waits
        for (int i = 1; i <= HM; i++) begin
            step_a();
            n_tests++;
            if (owner_a !== 2'd1) begin
                n_fail++;
                $display("FAIL hold_before_limit: cyc %0d got owner=%0d want 1", i, owner_a);
            end
        end
        step_a();
        n_tests++;
        if (owner_a !== 2'd2 || chg_a !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_force: got owner=%0d chg=%b want 2/1", owner_a, chg_a);
        end
        req_a = 4'b1101;
        step_a();
        req_a = 4'b1001; as_a = 4'b1101; // master 1 mid-transaction
        for (int i = 0; i < 10; i++) begin
            step_a();
            n_tests++;
            if (owner_a !== 2'd1) begin
                n_fail++;
                $display("FAIL hold_as_low: cyc %0d got owner=%0d want 1", i, owner_a);
            end
        end
        as_a = 4'b1111;
        step_a();
        n_tests++;
        if (owner_a !== 2'd2 || chg_a !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_as_release: got owner=%0d chg=%b want 2/1", owner_a, chg_a);
        end
    endtask

    task automatic test_hold_zero();
        req_b = 4'b0000; as_b = 4'b1111;
        req_a = 4'b1111;
        for (int i = 0; i < 100; i++) begin
            step_a();
            n_tests++;
            if (owner_b !== 2'd0 || grnt_b !== 4'b1110) begin
                n_fail++;
                $display("FAIL hold_zero: cyc %0d got owner=%0d grnt=%b want 0/1110", i, owner_b, grnt_b);
            end
        end
        req_b = 4'b1111;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_a = 4'($urandom);
            as_a  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            step_a();
            n_tests++;
            if ({grnt_a, owner_a, chg_a} !== {exp_grnt(m_owner), m_owner[1:0], m_chg}) begin
                n_fail++;
                $display("FAIL random_model: cyc %0d req=%b as=%b got grnt=%b owner=%0d chg=%b want grnt=%b owner=%0d chg=%b",
                         i, req_a, as_a, grnt_a, owner_a, chg_a, exp_grnt(m_owner), m_owner, m_chg);
            end
        end
        as_a = 4'b1111;
    endtask

    task automatic test_async_reset();
        req_a = 4'b1110;
        step_a();
        req_a = 4'b1011;
        step_a();
        n_tests++;
        if (owner_a !== 2'd2 || chg_a !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup: got owner=%0d chg=%b want 2/1", owner_a, chg_a);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if ({grnt_a, owner_a, chg_a} !== {4'b1110, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got grnt=%b owner=%0d chg=%b want 1110/0/0", grnt_a, owner_a, chg_a);
        end
        @(negedge clk);
        reset = 1'b1;
        req_a = 4'b1111;
        model_reset();
        step_a();
        n_tests++;
        if ({grnt_a, owner_a, chg_a} !== {4'b1110, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_release: got grnt=%b owner=%0d chg=%b want 1110/0/0", grnt_a, owner_a, chg_a);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_hold_limit();
        test_hold_zero();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
